exe_stage: RTL



---
 rtl/exe_stage.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// Execute stage: E/W elastic register pair around the 4-bit-encoded ALU.
// Optional perf counters enabled by defining EXE_PERF_CNT_EN.

module alu (
    input  logic [3:0]  ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    localparam logic [3:0] OP_ZERO = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SGE  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SRL  = 4'b1011;
    localparam logic [3:0] OP_SLA  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_LUI  = 4'b1110;
    localparam logic [3:0] OP_LDI  = 4'b1111;

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;

    // src1 supplies the shift amount, src2 is the value being shifted
    assign shamt = a[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    always_comb begin
        y = '0;
        unique case (ctrl)
            OP_ZERO: y = '0;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_SLT:  y = {31'd0, lt_s};
            OP_SGE:  y = {31'd0, ~lt_s};
            OP_SLTU: y = {31'd0, lt_u};
            OP_AND:  y = a & b;
            OP_NOR:  y = ~(a | b);
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = b << shamt;
            OP_SRL:  y = b >> shamt;
            OP_SLA:  y = b << shamt;
            OP_SRA:  y = $unsigned($signed(b) >>> shamt);
            OP_LUI:  y = {b[15:0], 16'd0};
            OP_LDI:  y = b;
            default: y = '0;
        endcase
    end
endmodule

module exe_stage #(
    parameter int ADDR_W         = 5,
    parameter int ZERO_DEST_NOWR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [3:0]        id_alu_control,
    input  logic [31:0]       id_src1,
    input  logic [31:0]       id_src2,
    input  logic [ADDR_W-1:0] id_dest,
    input  logic              id_wen,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_result,
    output logic [ADDR_W-1:0] wb_dest,
    output logic              wb_wen,
    output logic              fwd_e_valid,
    output logic [ADDR_W-1:0] fwd_e_dest,
    output logic              fwd_w_valid,
    output logic [ADDR_W-1:0] fwd_w_dest,
    output logic [31:0]       fwd_w_result,
    output logic [31:0]       op_count,
    output logic [31:0]       stall_count
);
    logic              e_valid;
    logic [3:0]        e_ctrl;
    logic [31:0]       e_src1;
    logic [31:0]       e_src2;
    logic [ADDR_W-1:0] e_dest;
    logic              e_wen;

    logic        w_free;
    logic        e_adv;
    logic        take;
    logic        zero_kill;
    logic [31:0] alu_y;

    assign w_free    = ~wb_valid | wb_ready;
    assign e_adv     = e_valid & w_free;
    assign id_ready  = ~e_valid | e_adv;
    assign take      = id_valid & id_ready;
    assign zero_kill = (ZERO_DEST_NOWR != 0) && (id_dest == '0);

    alu u_alu (
        .ctrl (e_ctrl),
        .a    (e_src1),
        .b    (e_src2),
        .y    (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid <= 1'b0;
            e_ctrl  <= '0;
            e_src1  <= '0;
            e_src2  <= '0;
            e_dest  <= '0;
            e_wen   <= 1'b0;
        end else if (flush) begin
            e_valid <= 1'b0;
        end else if (take) begin
            e_valid <= 1'b1;
            e_ctrl  <= id_alu_control;
            e_src1  <= id_src1;
            e_src2  <= id_src2;
            e_dest  <= id_dest;
            e_wen   <= id_wen & ~zero_kill;
        end else if (e_adv) begin
            e_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_result <= '0;
            wb_dest   <= '0;
            wb_wen    <= 1'b0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
        end else if (e_adv) begin
            wb_valid  <= 1'b1;
            wb_result <= alu_y;
            wb_dest   <= e_dest;
            wb_wen    <= e_wen;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

    assign fwd_e_valid  = e_valid & e_wen;
    assign fwd_e_dest   = e_dest;
    assign fwd_w_valid  = wb_valid & wb_wen;
    assign fwd_w_dest   = wb_dest;
    assign fwd_w_result = wb_result;

`ifdef EXE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count    <= '0;
            stall_count <= '0;
        end else if (!flush) begin
            if (wb_valid & wb_ready)
                op_count <= op_count + 32'd1;
            if (id_valid & ~id_ready)
                stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign op_count    = '0;
    assign stall_count = '0;
`endif
endmodule
